// File: rtl/id_stage_hazard.sv
// ID stage: decode, 32x32 register file, sign-extend, load-use stall, ID/EX register.
// Optional WB_BYPASS_EN: same-cycle WB write is visible to the ID register read.
module id_stage_hazard #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] PC_plus_four_in,
    input  logic [31:0]       instruction_in,
    input  logic              valid_in,
    input  logic              RegWrite_wb,
    input  logic [4:0]        write_reg_wb,
    input  logic [DATA_W-1:0] write_data_wb,
    output logic              stall,
    output logic [DATA_W-1:0] PC_plus_four_out,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] sign_ext_imm,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              Branch,
    output logic              ALUSrc,
    output logic              RegDst,
    output logic [1:0]        ALUOp,
    output logic              illegal_op
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    ctrl_t             ctrl_d, ctrl_q;
    logic [DATA_W-1:0] pc_q, rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
    logic [4:0]        rs_q, rt_q, rd_q;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic       wb_en;

    assign opcode = instruction_in[31:26];
    assign rs     = instruction_in[25:21];
    assign rt     = instruction_in[20:16];
    assign rd     = instruction_in[15:11];
    assign imm_d  = {{(DATA_W-16){instruction_in[15]}}, instruction_in[15:0]};
    assign wb_en  = RegWrite_wb && (write_reg_wb != 5'd0);

    // Compares against the registered ID/EX load, so the bubble it inserts clears it next cycle.
    assign stall = !reset && valid_in && ctrl_q.mem_read && (rt_q != 5'd0) &&
                   ((rt_q == rs) || (rt_q == rt));

    always_comb begin
        rd1_d = (rs == 5'd0) ? '0 : regs_q[rs];
        rd2_d = (rt == 5'd0) ? '0 : regs_q[rt];
`ifdef WB_BYPASS_EN
        if (wb_en && (write_reg_wb == rs)) rd1_d = write_data_wb;
        if (wb_en && (write_reg_wb == rt)) rd2_d = write_data_wb;
`endif
    end

    always_comb begin
        ctrl_d = '0;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = 2'b10;
            end
            OP_LW: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
            end
            OP_SW: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.alu_op = 2'b01;
            end
            OP_ADDI: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
        if (!valid_in || stall) ctrl_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_en) begin
            regs_q[write_reg_wb] <= write_data_wb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q <= '0;
            pc_q   <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pc_q   <= PC_plus_four_in;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            rs_q   <= rs;
            rt_q   <= rt;
            rd_q   <= rd;
        end
    end

    assign PC_plus_four_out = pc_q;
    assign read_data_1      = rd1_q;
    assign read_data_2      = rd2_q;
    assign sign_ext_imm     = imm_q;
    assign rs_out           = rs_q;
    assign rt_out           = rt_q;
    assign rd_out           = rd_q;
    assign RegWrite         = ctrl_q.reg_write;
    assign MemtoReg         = ctrl_q.mem_to_reg;
    assign MemRead          = ctrl_q.mem_read;
    assign MemWrite         = ctrl_q.mem_write;
    assign Branch           = ctrl_q.branch;
    assign ALUSrc           = ctrl_q.alu_src;
    assign RegDst           = ctrl_q.reg_dst;
    assign ALUOp            = ctrl_q.alu_op;
    assign illegal_op       = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed table-driven bench for id_stage_hazard (default and WB_BYPASS_EN builds).
module tb_id_stage_hazard;

    logic        clock = 1'b0;
    logic        reset, valid_in, RegWrite_wb;
    logic [31:0] PC_plus_four_in, instruction_in, write_data_wb;
    logic [4:0]  write_reg_wb;
    logic        stall;
    logic [31:0] PC_plus_four_out, read_data_1, read_data_2, sign_ext_imm;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic        RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, illegal_op;
    logic [1:0]  ALUOp;

    always #5 clock = ~clock;

    id_stage_hazard dut (
        .clock(clock), .reset(reset), .PC_plus_four_in(PC_plus_four_in),
        .instruction_in(instruction_in), .valid_in(valid_in), .RegWrite_wb(RegWrite_wb),
        .write_reg_wb(write_reg_wb), .write_data_wb(write_data_wb), .stall(stall),
        .PC_plus_four_out(PC_plus_four_out), .read_data_1(read_data_1),
        .read_data_2(read_data_2), .sign_ext_imm(sign_ext_imm), .rs_out(rs_out),
        .rt_out(rt_out), .rd_out(rd_out), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUSrc(ALUSrc),
        .RegDst(RegDst), .ALUOp(ALUOp), .illegal_op(illegal_op)
    );

    // {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,RegDst,ALUOp[1:0],illegal_op}
    localparam logic [9:0] C_NONE = 10'b0000000000;
    localparam logic [9:0] C_R    = 10'b1000001100;
    localparam logic [9:0] C_LW   = 10'b1110010000;
    localparam logic [9:0] C_SW   = 10'b0001010000;
    localparam logic [9:0] C_BEQ  = 10'b0000100010;
    localparam logic [9:0] C_ADDI = 10'b1000010000;
    localparam logic [9:0] C_ILL  = 10'b0000000001;

    localparam logic [31:0] I_NOP    = 32'h00000000;
    localparam logic [31:0] I_ADD988 = 32'h01084820;
    localparam logic [31:0] I_LW8    = 32'h8C080004;
    localparam logic [31:0] I_ADDI   = 32'h2001FFFF;
    localparam logic [31:0] I_ADD200 = 32'h00001020;
    localparam logic [31:0] I_ILL    = 32'hFC000000;
    localparam logic [31:0] I_SW     = 32'hAC090008;
    localparam logic [31:0] I_BEQ    = 32'h1108FFFE;
    localparam logic [31:0] I_ADD080 = 32'h01000020;
    localparam logic [31:0] I_LW0    = 32'h8C000000;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] BYP_VAL = 32'hCAFEF00D;
`else
    localparam logic [31:0] BYP_VAL = 32'h00001234;
`endif

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        e_stall;
        logic [9:0]  e_ctrl;
        logic        chk;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_imm;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(logic rst, logic vld, logic [31:0] pc, logic [31:0] instr,
                                logic wen, logic [4:0] wreg, logic [31:0] wdata,
                                logic e_stall, logic [9:0] e_ctrl, logic chk,
                                logic [31:0] e_rd1, logic [31:0] e_rd2, logic [31:0] e_imm);
        vec_t v;
        v.rst = rst; v.vld = vld; v.pc = pc; v.instr = instr;
        v.wen = wen; v.wreg = wreg; v.wdata = wdata;
        v.e_stall = e_stall; v.e_ctrl = e_ctrl; v.chk = chk;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_imm = e_imm;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        logic [31:0] ins;
        ins            = v.instr;
        reset          = v.rst;
        valid_in       = v.vld;
        PC_plus_four_in = v.pc;
        instruction_in = ins;
        RegWrite_wb    = v.wen;
        write_reg_wb   = v.wreg;
        write_data_wb  = v.wdata;
        #1;
        chk("stall", idx, {31'd0, stall}, {31'd0, v.e_stall});
        @(posedge clock);
        #1;
        chk("ctrl", idx, {22'd0, RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc,
                          RegDst, ALUOp, illegal_op}, {22'd0, v.e_ctrl});
        if (v.chk) begin
            chk("pc4", idx, PC_plus_four_out, v.rst ? 32'd0 : v.pc);
            chk("rd1", idx, read_data_1, v.e_rd1);
            chk("rd2", idx, read_data_2, v.e_rd2);
            chk("imm", idx, sign_ext_imm, v.e_imm);
            chk("rs", idx, {27'd0, rs_out}, v.rst ? 32'd0 : {27'd0, ins[25:21]});
            chk("rt", idx, {27'd0, rt_out}, v.rst ? 32'd0 : {27'd0, ins[20:16]});
            chk("rd", idx, {27'd0, rd_out}, v.rst ? 32'd0 : {27'd0, ins[15:11]});
        end
    endtask

    vec_t tbl [20];

    initial begin
        reset = 1'b1; valid_in = 1'b0; RegWrite_wb = 1'b0; write_reg_wb = '0;
        write_data_wb = '0; PC_plus_four_in = '0; instruction_in = '0;

        //          rst vld pc           instr     wen wreg   wdata         stl ctrl   chk rd1           rd2           imm
        tbl[0]  = mk(1, 1, 32'h100, I_ADD988, 0, 5'd0, 32'h0,        0, C_NONE, 1, 32'h0,        32'h0,        32'h0);
        tbl[1]  = mk(1, 1, 32'h100, I_LW8,    1, 5'd8, 32'h77,       0, C_NONE, 1, 32'h0,        32'h0,        32'h0);
        tbl[2]  = mk(0, 1, 32'h100, I_NOP,    1, 5'd8, 32'h1234,     0, C_R,    1, 32'h0,        32'h0,        32'h0);
        tbl[3]  = mk(0, 1, 32'h104, I_ADD988, 0, 5'd0, 32'h0,        0, C_R,    1, 32'h1234,     32'h1234,     32'h4820);
        tbl[4]  = mk(0, 1, 32'h108, I_LW8,    0, 5'd0, 32'h0,        0, C_LW,   1, 32'h0,        32'h1234,     32'h4);
        tbl[5]  = mk(0, 1, 32'h10C, I_ADD988, 0, 5'd0, 32'h0,        1, C_NONE, 0, 32'h0,        32'h0,        32'h0);
        tbl[6]  = mk(0, 1, 32'h10C, I_ADD988, 0, 5'd0, 32'h0,        0, C_R,    1, 32'h1234,     32'h1234,     32'h4820);
        tbl[7]  = mk(0, 1, 32'h110, I_ADD988, 1, 5'd8, 32'hCAFEF00D, 0, C_R,    1, BYP_VAL,      BYP_VAL,      32'h4820);
        tbl[8]  = mk(0, 1, 32'h114, I_ADD988, 0, 5'd0, 32'h0,        0, C_R,    1, 32'hCAFEF00D, 32'hCAFEF00D, 32'h4820);
        tbl[9]  = mk(0, 1, 32'h118, I_ADDI,   1, 5'd0, 32'h5,        0, C_ADDI, 1, 32'h0,        32'h0,        32'hFFFFFFFF);
        tbl[10] = mk(0, 1, 32'h11C, I_ADD200, 0, 5'd0, 32'h0,        0, C_R,    1, 32'h0,        32'h0,        32'h1020);
        tbl[11] = mk(0, 1, 32'h120, I_ILL,    0, 5'd0, 32'h0,        0, C_ILL,  1, 32'h0,        32'h0,        32'h0);
        tbl[12] = mk(0, 0, 32'h124, I_ILL,    0, 5'd0, 32'h0,        0, C_NONE, 0, 32'h0,        32'h0,        32'h0);
        tbl[13] = mk(0, 1, 32'h128, I_SW,     0, 5'd0, 32'h0,        0, C_SW,   1, 32'h0,        32'h0,        32'h8);
        tbl[14] = mk(0, 1, 32'h12C, I_BEQ,    0, 5'd0, 32'h0,        0, C_BEQ,  1, 32'hCAFEF00D, 32'hCAFEF00D, 32'hFFFFFFFE);
        tbl[15] = mk(0, 1, 32'h130, I_LW8,    0, 5'd0, 32'h0,        0, C_LW,   1, 32'h0,        32'hCAFEF00D, 32'h4);
        tbl[16] = mk(0, 1, 32'h134, I_ADD080, 0, 5'd0, 32'h0,        1, C_NONE, 0, 32'h0,        32'h0,        32'h0);
        tbl[17] = mk(0, 1, 32'h134, I_ADD080, 0, 5'd0, 32'h0,        0, C_R,    1, 32'hCAFEF00D, 32'h0,        32'h20);
        tbl[18] = mk(0, 1, 32'h138, I_LW0,    0, 5'd0, 32'h0,        0, C_LW,   1, 32'h0,        32'h0,        32'h0);
        tbl[19] = mk(0, 1, 32'h13C, I_ADD200, 0, 5'd0, 32'h0,        0, C_R,    1, 32'h0,        32'h0,        32'h1020);

        for (int i = 0; i < 20; i++) step(tbl[i], i);

        // Reset landing on a pending load-use stall: stall dropped, bubble, regfile cleared.
        step(mk(0, 1, 32'h200, I_LW8,    0, 5'd0, 32'h0, 0, C_LW,   1, 32'h0, 32'hCAFEF00D, 32'h4), 100);
        step(mk(1, 1, 32'h204, I_ADD988, 0, 5'd0, 32'h0, 0, C_NONE, 1, 32'h0, 32'h0,        32'h0), 101);
        step(mk(0, 1, 32'h204, I_ADD988, 0, 5'd0, 32'h0, 0, C_R,    1, 32'h0, 32'h0,        32'h4820), 102);

        // A held load with valid_in low must not stall.
        step(mk(0, 1, 32'h208, I_LW8,    0, 5'd0, 32'h0, 0, C_LW,   1, 32'h0, 32'h0,        32'h4), 103);
        step(mk(0, 0, 32'h20C, I_ADD988, 0, 5'd0, 32'h0, 0, C_NONE, 0, 32'h0, 32'h0,        32'h0), 104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
